// File: rtl/chunked_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : chunked_adder_pkg
// Description : Shared constants, FSM state encoding and helpers for the
//               multi-cycle chunked ripple-carry adder.
// Revision    : 1.0 - initial release
// ============================================================================
package chunked_adder_pkg;

    // Default operand width and per-cycle chunk width
    localparam int c_default_width = 32;
    localparam int c_default_chunk = 8;

    // Controller states, explicitly encoded in two bits
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Width of a counter able to index n items; never less than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : chunked_adder_pkg
`default_nettype wire

// File: rtl/chunked_adder_if.sv
`default_nettype none
// ============================================================================
// Module      : chunked_adder_if
// Description : Operand/result handshake bundle for chunked_adder.
//               master = producer/consumer side, slave = adder side.
// Revision    : 1.0 - initial release
// ============================================================================
interface chunked_adder_if
    import chunked_adder_pkg::*;
#(
    parameter int WIDTH = c_default_width
) ();

    // Operation request
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c0;
    logic             sub;

    // Result
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             ovf;

    modport master (
        output in_valid, a, b, c0, sub, out_ready,
        input  in_ready, out_valid, s, c, ovf
    );

    modport slave (
        input  in_valid, a, b, c0, sub, out_ready,
        output in_ready, out_valid, s, c, ovf
    );

endinterface : chunked_adder_if
`default_nettype wire

// File: rtl/chunked_adder_rca_chunk.sv
`default_nettype none
// ============================================================================
// Module      : full_adder / rca_chunk
// Description : One-bit full adder and a CHUNK-wide ripple-carry adder built
//               from it. rca_chunk also exposes the carry into its MSB so the
//               caller can form two's-complement overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
    input  wire logic a,
    input  wire logic b,
    input  wire logic ci,
    output logic      s,
    output logic      co
);

    logic w_p;

    // Propagate term shared by sum and carry
    assign w_p = a ^ b;
    assign s   = w_p ^ ci;
    assign co  = (a & b) | (ci & w_p);

endmodule : full_adder

module rca_chunk
    import chunked_adder_pkg::*;
#(
    parameter int CHUNK = c_default_chunk
) (
    input  wire logic [CHUNK-1:0] a,
    input  wire logic [CHUNK-1:0] b,
    input  wire logic             c0,
    output logic      [CHUNK-1:0] s,
    output logic                  c,
    output logic                  c_msb
);

    // w_carry[i] is the carry into bit i; w_carry[CHUNK] is the carry-out
    logic [CHUNK:0] w_carry;

    assign w_carry[0] = c0;

    generate
        for (genvar gi = 0; gi < CHUNK; gi++) begin : g_bit
            full_adder u_fa (
                .a  (a[gi]),
                .b  (b[gi]),
                .ci (w_carry[gi]),
                .s  (s[gi]),
                .co (w_carry[gi+1])
            );
        end
    endgenerate

    assign c     = w_carry[CHUNK];
    assign c_msb = w_carry[CHUNK-1];

endmodule : rca_chunk
`default_nettype wire

// File: rtl/chunked_adder.sv
`default_nettype none
// ============================================================================
// Module      : chunked_adder
// Description : Multi-cycle adder/subtractor. Adds CHUNK bits per clock
//               through a single shared ripple-carry chunk, LSB chunk first,
//               with valid/ready handshakes on both sides. Subtraction is
//               a + ~b + 1.
// Revision    : 1.0 - initial release
// ============================================================================
module chunked_adder
    import chunked_adder_pkg::*;
#(
    parameter int WIDTH = c_default_width,
    parameter int CHUNK = c_default_chunk
) (
    input  wire logic      clk,
    input  wire logic      rst,
    chunked_adder_if.slave bus
);

    localparam int c_nchunk = WIDTH / CHUNK;
    localparam int c_kw     = idx_width(c_nchunk);

    // Reject configurations where the operand does not split evenly
    generate
        if ((CHUNK < 1) || (WIDTH < CHUNK) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
            $error("chunked_adder: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t            r_state;
    state_t            w_state_next;
    logic [c_kw-1:0]   r_k;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_carry;
    logic [WIDTH-1:0]  r_s;
    logic              r_c;
    logic              r_ovf;

    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_accept;
    logic              w_last;

    // Shared chunk adder connections
    logic [CHUNK-1:0]  w_a_chunk;
    logic [CHUNK-1:0]  w_b_chunk;
    logic [CHUNK-1:0]  w_sum_chunk;
    logic              w_cout;
    logic              w_cmsb;
    int                w_base;

    assign w_last = (r_k == c_kw'(c_nchunk - 1));

    // ------------------------------------------------------------------------
    // Chunk selection and the single shared ripple adder
    // ------------------------------------------------------------------------
    assign w_base    = int'(r_k) * CHUNK;
    assign w_a_chunk = r_a[w_base +: CHUNK];
    assign w_b_chunk = r_b[w_base +: CHUNK];

    rca_chunk #(
        .CHUNK (CHUNK)
    ) u_rca (
        .a     (w_a_chunk),
        .b     (w_b_chunk),
        .c0    (r_carry),
        .s     (w_sum_chunk),
        .c     (w_cout),
        .c_msb (w_cmsb)
    );

    // ------------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------------

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and handshake outputs; accept only from IDLE, release only from DONE
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------

    // Capture operands on accept, then ripple one chunk per RUN cycle LSB first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_k     <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_s     <= '0;
            r_c     <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            // Subtraction inverts b here; the +1 enters as the initial carry
            r_a     <= bus.a;
            r_b     <= bus.b ^ {WIDTH{bus.sub}};
            r_carry <= bus.sub ? 1'b1 : bus.c0;
            r_k     <= '0;
        end else if (r_state == S_RUN) begin
            r_s[w_base +: CHUNK] <= w_sum_chunk;
            r_carry              <= w_cout;
            r_k                  <= r_k + c_kw'(1);
            if (w_last) begin
                r_c   <= w_cout;
                r_ovf <= w_cout ^ w_cmsb;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.s         = r_s;
    assign bus.c         = r_c;
    assign bus.ovf       = r_ovf;

endmodule : chunked_adder
`default_nettype wire

// File: doc/chunked_adder.md
CHUNKED_ADDER -- requirements
Module: chunked_adder

Interface
REQ-001 Parameter WIDTH, default 32: operand and sum width in bits.
REQ-002 Parameter CHUNK, default 8: bits added per clock cycle; WIDTH SHALL be an integer multiple of CHUNK, checked at elaboration; NCHUNK = WIDTH/CHUNK.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  clock; all state changes on rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 in_valid  in  1  operands and mode valid.
REQ-007 in_ready  out  1  block can accept an operation.
REQ-008 a, b  in  WIDTH each  operands.
REQ-009 c0  in  1  carry-in; used only when sub=0.
REQ-010 sub  in  1  0 = a+b+c0; 1 = a-b, computed as a+~b+1; c0 ignored.
REQ-011 out_valid  out  1  result valid.
REQ-012 out_ready  in  1  consumer accepts result.
REQ-013 s  out  WIDTH  sum or difference.
REQ-014 c  out  1  carry-out of MSB; for sub=1, 1 means no borrow.
REQ-015 ovf  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

Function
REQ-016 FSM states: IDLE, RUN, DONE.
REQ-017 IDLE: in_ready=1 and out_valid=0.
REQ-018 On in_valid in IDLE: register a, b XOR {WIDTH{sub}}, and initial carry (sub ? 1 : c0); clear chunk index; go to RUN.
REQ-019 RUN: in_ready=0; each cycle add chunk k (bits k*CHUNK+CHUNK-1 : k*CHUNK) with the registered carry; write the result into the same bits of s; register the chunk carry-out; increment k.
REQ-020 On the cycle that processes chunk NCHUNK-1: latch c and ovf; go to DONE.
REQ-021 Latency: if the operation is accepted at edge T, out_valid SHALL rise at edge T+NCHUNK.
REQ-022 DONE: out_valid=1, in_ready=0; s, c and ovf are held stable until out_ready=1.
REQ-023 DONE with out_ready=1: return to IDLE next edge; out_valid falls and in_ready rises at that edge; there is no same-cycle accept of the next operation.
REQ-024 out_ready is ignored outside DONE; in_valid is ignored outside IDLE.
REQ-025 s bits of chunks not yet processed are don't-care while in RUN; s is only meaningful when out_valid=1.
REQ-026 CHUNK=WIDTH is legal: single RUN cycle, latency 1.
REQ-027 Arithmetic is modulo 2^WIDTH; no saturation.

Reset
REQ-028 While rst=1, regardless of clock: state=IDLE, k=0, out_valid=0, s=0, c=0, ovf=0, internal carry=0.
REQ-029 Reset asserted mid-RUN or in DONE SHALL abort the operation with no partial result presented; after release, in_ready=1.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding (IDLE/RUN/DONE) and the default WIDTH/CHUNK constants.
REQ-031 The combinational chunk adder SHALL be one sub-module, rca_chunk, with a CHUNK-wide ripple of full_adder instances, ports a, b, c0, s, c and additionally the carry into its MSB, which is needed for ovf.
REQ-032 chunked_adder instantiates exactly one rca_chunk and selects the chunk by index k.

Verification (WIDTH=32, CHUNK=8 unless stated)
REQ-033 a=0xFFFFFFFF, b=1, c0=0, sub=0 -> s=0x00000000, c=1, ovf=0, out_valid exactly 4 cycles after accept.
REQ-034 a=0x7FFFFFFF, b=1, sub=0 -> s=0x80000000, c=0, ovf=1; a=5, b=7, sub=1 -> s=0xFFFFFFFE, c=0, ovf=0.
REQ-035 Backpressure: result with out_ready=0 for 10 cycles -> out_valid, s, c, ovf stable; in_ready=0 throughout; in_valid pulses are ignored.
REQ-036 rst pulse during RUN (after 2 chunks) -> out_valid never asserts for that operation; the next operation, a=0x12345678, b=0x11111111, gives s=0x23456789.
REQ-037 WIDTH=16, CHUNK=16: a=0x8000, b=0x8000 -> s=0x0000, c=1, ovf=1, latency 1 cycle.
REQ-038 Random back-to-back operations with random out_ready are checked against a reference model of a+b+c0 / a-b.
